// File: rtl/mem_pkg.sv
// mem_pkg: shared status codes, FSM encoding and op type for the memory stall source.
package mem_pkg;
  localparam logic [2:0] MEM_FREE  = 3'b000;
  localparam logic [2:0] MEM_STALL = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/mem_stall_source_if.sv
// mem_stall_source_if: CPU-to-memory request bus and 3-bit status return.
interface mem_stall_source_if #(parameter int DATA_W = 32, parameter int ADDR_W = 8);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        state;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  modport master (output mem_read, mem_write, addr, wdata, input state, rdata, ack);
  modport slave  (input mem_read, mem_write, addr, wdata, output state, rdata, ack);
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port synchronous word array; rdata only updates on a read strobe.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  always_comb rdata_d = re ? mem[addr] : rdata_q;
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk)
    rdata_q <= rst ? '0 : rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/mem_stall_source.sv
// mem_stall_source: memory responder holding STALL for LATENCY cycles per access, then a one-cycle ack.
module mem_stall_source
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 4
) (
  input logic                clk,
  input logic                rst,
  mem_stall_source_if.slave  bus
);
  fsm_t              fsm_d, fsm_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  op_t               op_d, op_q;
  logic [2:0]        state_d, state_q;
  logic              ack_d, ack_q;
  logic              we, re;
  logic [DATA_W-1:0] rdata;
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    state_d = MEM_FREE;
    ack_d   = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    case (fsm_q)
      IDLE:
        if (bus.mem_read || bus.mem_write) begin
          fsm_d   = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          op_d    = bus.mem_write ? OP_WRITE : OP_READ;
          state_d = MEM_STALL;
        end
      BUSY:
        if (cnt_q == '0) begin
          // a reset landing on the execute edge aborts the write too
          fsm_d = DONE;
          ack_d = 1'b1;
          we    = !rst && op_q == OP_WRITE;
          re    = op_q == OP_READ;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = MEM_STALL;
        end
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      state_q <= MEM_FREE;
      ack_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );
  assign bus.state = state_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata;
endmodule
